// File: rtl/pc_gen_stage_pkg.sv
// Shared fetch-path constants and redirect kind encoding.
// Kind values are ordered so that a larger value means a higher redirect priority.
package pc_gen_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam logic [31:0] EXC_PC   = 32'hbfc00380;

  typedef enum logic [1:0] {
    RK_NONE = 2'd0,
    RK_BR   = 2'd1,
    RK_ERET = 2'd2,
    RK_EXC  = 2'd3
  } redir_kind_e;

endpackage

// File: rtl/redirect_hold.sv
// Holds a redirect that arrives while fetch is stalled until the stall releases.
// While stalled, an incoming redirect replaces the held one only if its priority is the same or higher.
module redirect_hold
  import pc_gen_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  redir_kind_e live_kind,
  input  logic [31:0] live_addr,
  output logic        pend_valid,
  output redir_kind_e pend_kind,
  output logic [31:0] pend_addr
);

  logic take_live;

  assign take_live = (live_kind != RK_NONE) && (!pend_valid || (live_kind >= pend_kind));

  // Any non-stall edge consumes or discards the held entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_valid <= 1'b0;
      pend_kind  <= RK_NONE;
      pend_addr  <= 32'd0;
    end else if (stall) begin
      if (take_live) begin
        pend_valid <= 1'b1;
        pend_kind  <= live_kind;
        pend_addr  <= live_addr;
      end
    end else begin
      pend_valid <= 1'b0;
      pend_kind  <= RK_NONE;
    end
  end

endmodule

// File: rtl/pc_gen_stage.sv
// Fetch request stage: selects the next PC, drives the instruction SRAM request,
// and tracks the registered address of the read that is in flight.
module pc_gen_stage #(
  parameter logic [31:0] RESET_PC = pc_gen_stage_pkg::RESET_PC,
  parameter logic [31:0] EXC_PC   = pc_gen_stage_pkg::EXC_PC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        exception,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_raddr,
  output logic        raddr_valid,
  output logic        fetch_adel
);

  import pc_gen_stage_pkg::*;

  logic [31:0] pc_q;
  logic [31:0] next_raw;
  logic [31:0] live_addr;
  redir_kind_e live_kind;
  logic        pend_valid;
  redir_kind_e pend_kind;
  logic [31:0] pend_addr;
  logic        use_pend;

  always_comb begin
    live_kind = RK_NONE;
    live_addr = 32'd0;
    if (exception) begin
      live_kind = RK_EXC;
      live_addr = EXC_PC;
    end else if (eret) begin
      live_kind = RK_ERET;
      live_addr = epc;
    end else if (br_valid) begin
      live_kind = RK_BR;
      live_addr = br_target;
    end
  end

  redirect_hold u_redirect_hold (
    .clk        (clk),
    .resetn     (resetn),
    .stall      (stall),
    .live_kind  (live_kind),
    .live_addr  (live_addr),
    .pend_valid (pend_valid),
    .pend_kind  (pend_kind),
    .pend_addr  (pend_addr)
  );

  // A held redirect beats a live branch but yields to a live exception or eret.
  assign use_pend = pend_valid && (live_kind <= RK_BR) && (pend_kind >= live_kind);

  always_comb begin
    next_raw = pc_q + 32'd4;
    if (stall) begin
      next_raw = pc_q;
    end else if (live_kind >= RK_ERET) begin
      next_raw = live_addr;
    end else if (use_pend) begin
      next_raw = pend_addr;
    end else if (live_kind == RK_BR) begin
      next_raw = live_addr;
    end
  end

  // A misaligned target is issued word-aligned; the fault flag follows it into raddr.
  assign inst_sram_addr  = {next_raw[31:2], 2'b00};
  assign inst_sram_en    = resetn;
  assign inst_sram_raddr = pc_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q        <= RESET_PC - 32'd4;
      raddr_valid <= 1'b0;
      fetch_adel  <= 1'b0;
    end else if (!stall) begin
      pc_q        <= inst_sram_addr;
      raddr_valid <= 1'b1;
      fetch_adel  <= |next_raw[1:0];
    end
  end

endmodule

// File: tb/tb_pc_gen_stage.sv
// Self-checking bench for pc_gen_stage: per-cycle vector table plus a raddr scoreboard,
// followed by a reset-during-pending sequence.
module tb_pc_gen_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall;
  logic        exception;
  logic        eret;
  logic [31:0] epc;
  logic        br_valid;
  logic [31:0] br_target;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_raddr;
  logic        raddr_valid;
  logic        fetch_adel;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        stall;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic        br;
    logic [31:0] bt;
    logic [31:0] exp_addr;
    logic        exp_rv;
    logic        exp_adel;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        adel;
  } rexp_t;

  vec_t  vecs[$];
  rexp_t sb[$];

  always #5 clk = ~clk;

  pc_gen_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .exception       (exception),
    .eret            (eret),
    .epc             (epc),
    .br_valid        (br_valid),
    .br_target       (br_target),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_raddr (inst_sram_raddr),
    .raddr_valid     (raddr_valid),
    .fetch_adel      (fetch_adel)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic x, input logic e, input logic [31:0] ep,
                              input logic b, input logic [31:0] bt, input logic [31:0] ea,
                              input logic rv, input logic ad);
    vec_t v;
    v.stall = s; v.exc = x; v.eret = e; v.epc = ep; v.br = b; v.bt = bt;
    v.exp_addr = ea; v.exp_rv = rv; v.exp_adel = ad;
    return v;
  endfunction

  initial begin
    rexp_t e;
    //                  stall exc eret epc           br  target        addr          rv  adel
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00004, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00008, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hbfc00100, 32'hbfc00100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00104, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00104, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'hbfc00200, 32'hbfc00104, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00104, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00200, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'hbfc00200, 32'hbfc00200, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'hbfc00200, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'hbfc00300, 32'hbfc00200, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00380, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00384, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'hbfc00012, 0, 32'h0,        32'hbfc00010, 1, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'hbfc00500, 32'hbfc00380, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00384, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'hbfc00040, 1, 32'hbfc00600, 32'hbfc00040, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'hbfc00700, 32'hbfc00040, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'hbfc00800, 0, 32'h0,        32'hbfc00800, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00804, 1, 0));
    vecs.push_back(mk(1, 0, 1, 32'hbfc00900, 0, 32'h0,        32'hbfc00804, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hbfc00a00, 32'hbfc00900, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00904, 1, 0));
    vecs.push_back(mk(1, 0, 1, 32'hbfc00b00, 0, 32'h0,        32'hbfc00904, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'hbfc00c00, 32'hbfc00904, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00b00, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'hbfc00d00, 32'hbfc00b00, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'hbfc00e00, 32'hbfc00b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hbfc00e00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hfffffffc, 32'hfffffffc, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h00000000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h00000004, 1, 0));

    resetn = 1'b0; stall = 1'b0; exception = 1'b0; eret = 1'b0;
    epc = 32'h0; br_valid = 1'b0; br_target = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_en",    {31'd0, inst_sram_en}, 32'd0);
    chk("reset_raddr", inst_sram_raddr, 32'hbfbffffc);
    chk("reset_rv",    {31'd0, raddr_valid}, 32'd0);
    chk("reset_adel",  {31'd0, fetch_adel}, 32'd0);

    @(posedge clk); #1;
    resetn = 1'b1;
    sb.push_back('{addr: 32'hbfbffffc, adel: 1'b0});

    foreach (vecs[i]) begin
      stall = vecs[i].stall; exception = vecs[i].exc; eret = vecs[i].eret;
      epc = vecs[i].epc; br_valid = vecs[i].br; br_target = vecs[i].bt;
      #4;
      chk($sformatf("addr[%0d]", i), inst_sram_addr, vecs[i].exp_addr);
      chk($sformatf("en[%0d]", i), {31'd0, inst_sram_en}, 32'd1);
      chk($sformatf("rv[%0d]", i), {31'd0, raddr_valid}, {31'd0, vecs[i].exp_rv});
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty[%0d] actual=empty required=entry", i);
        e = '{addr: 32'h0, adel: 1'b0};
      end else begin
        e = sb.pop_front();
        chk($sformatf("raddr[%0d]", i), inst_sram_raddr, e.addr);
        chk($sformatf("adel[%0d]", i), {31'd0, fetch_adel}, {31'd0, e.adel});
      end
      if (vecs[i].stall) sb.push_back(e);
      else sb.push_back('{addr: vecs[i].exp_addr, adel: vecs[i].exp_adel});
      @(posedge clk); #1;
    end

    // Reset arriving while a branch is held in the pending register.
    stall = 1'b1; exception = 1'b0; eret = 1'b0; br_valid = 1'b1; br_target = 32'hbfc00f00;
    #4;
    chk("rst_seq_addr_stall", inst_sram_addr, 32'h00000004);
    @(posedge clk); #1;
    br_valid = 1'b0; resetn = 1'b0;
    #4;
    chk("rst_seq_en_low", {31'd0, inst_sram_en}, 32'd0);
    @(posedge clk); #1;
    chk("rst_seq_raddr", inst_sram_raddr, 32'hbfbffffc);
    chk("rst_seq_rv", {31'd0, raddr_valid}, 32'd0);
    chk("rst_seq_adel", {31'd0, fetch_adel}, 32'd0);
    resetn = 1'b1; stall = 1'b0;
    #4;
    chk("rst_seq_addr0", inst_sram_addr, 32'hbfc00000);
    chk("rst_seq_en_high", {31'd0, inst_sram_en}, 32'd1);
    chk("rst_seq_rv0", {31'd0, raddr_valid}, 32'd0);
    @(posedge clk); #1;
    #4;
    chk("rst_seq_addr1", inst_sram_addr, 32'hbfc00004);
    chk("rst_seq_raddr1", inst_sram_raddr, 32'hbfc00000);
    chk("rst_seq_rv1", {31'd0, raddr_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
